// File: rtl/ascii_dec_stream_decoder_if.sv
// Byte-in / result-out handshake bundle for the ASCII decimal stream decoder.
// The master side feeds bytes and consumes results; the slave side is the decoder.
interface ascii_dec_stream_decoder_if #(
    parameter int WIDTH = 20
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_value;
    logic [3:0]       out_digits;
    logic             out_valid;
    logic             out_ready;
    logic             out_error;
    logic [1:0]       out_err_code;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_value,
        input  out_digits,
        input  out_valid,
        output out_ready,
        input  out_error,
        input  out_err_code
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_value,
        output out_digits,
        output out_valid,
        input  out_ready,
        output out_error,
        output out_err_code
    );
endinterface

// File: rtl/ascii_dec_stream_decoder.sv
// Streaming ASCII-decimal to binary converter.
// Digits arrive most-significant first and are folded into an accumulator as
// acc*10 + digit. A terminator closes the field and produces one registered
// result carrying the value, the digit count and an error code. Bad characters,
// empty fields and overflow are reported rather than silently zeroed; after the
// first error the rest of the field is swallowed up to the terminator.
// The WIDTH parameter must match the WIDTH of the connected interface.
module ascii_dec_stream_decoder #(
    parameter int         WIDTH      = 20,
    parameter int         MAX_DIGITS = 7,
    parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ascii_dec_stream_decoder_if.slave   bus
);

    localparam int         EXT_W   = WIDTH + 4;
    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_BAD_CHAR = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_EMPTY    = 2'd3
    } err_t;

    state_t           state_q, state_n;
    err_t             err_q, err_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [3:0]       cnt_q, cnt_n;

    logic [WIDTH-1:0] out_value_q;
    logic [3:0]       out_digits_q;
    logic             out_valid_q;
    logic             out_error_q;
    logic [1:0]       out_err_code_q;
    logic             in_ready_q;

    logic             accept;
    logic             is_term;
    logic             is_digit;
    logic [3:0]       digit_val;
    logic [EXT_W-1:0] digit_ext;
    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] next_ext;
    logic             value_ovf;
    logic             cnt_full;

    assign accept    = bus.in_valid & in_ready_q;
    assign is_term   = (bus.in_data == TERM_CHAR);
    assign is_digit  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    // The low nibble of an ASCII digit is its numeric value.
    assign digit_val = bus.in_data[3:0];
    assign digit_ext = {{WIDTH{1'b0}}, digit_val};
    assign acc_ext   = {4'b0000, acc_q};
    // acc*10 built from two shifts; the four extra bits catch any carry past WIDTH.
    assign next_ext  = (acc_ext << 3) + (acc_ext << 1) + digit_ext;
    assign value_ovf = |next_ext[EXT_W-1:WIDTH];
    assign cnt_full  = (cnt_q == MAX_CNT);

    // Next-state and datapath updates for each accepted byte or result handshake.
    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_term) begin
                        err_n   = ERR_EMPTY;
                        state_n = DONE;
                    end else if (is_digit) begin
                        acc_n   = digit_ext[WIDTH-1:0];
                        cnt_n   = 4'd1;
                        state_n = ACCUM;
                    end else begin
                        err_n   = ERR_BAD_CHAR;
                        state_n = FLUSH;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (is_term) begin
                        state_n = DONE;
                    end else if (is_digit) begin
                        if (cnt_full || value_ovf) begin
                            err_n   = ERR_OVERFLOW;
                            state_n = FLUSH;
                        end else begin
                            acc_n = next_ext[WIDTH-1:0];
                            cnt_n = cnt_q + 4'd1;
                        end
                    end else begin
                        err_n   = ERR_BAD_CHAR;
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (accept && is_term) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    acc_n   = '0;
                    cnt_n   = 4'd0;
                    err_n   = ERR_OK;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, accumulator and registered result outputs; reset aborts any field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= 4'd0;
            err_q          <= ERR_OK;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_value_q    <= '0;
            out_digits_q   <= 4'd0;
            out_error_q    <= 1'b0;
            out_err_code_q <= 2'd0;
        end else begin
            state_q        <= state_n;
            acc_q          <= acc_n;
            cnt_q          <= cnt_n;
            err_q          <= err_n;
            in_ready_q     <= (state_n != DONE);
            out_valid_q    <= (state_n == DONE);
            out_value_q    <= ((state_n == DONE) && (err_n == ERR_OK)) ? acc_n : '0;
            out_digits_q   <= (state_n == DONE) ? cnt_n : 4'd0;
            out_error_q    <= (state_n == DONE) && (err_n != ERR_OK);
            out_err_code_q <= (state_n == DONE) ? err_n : ERR_OK;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_value    = out_value_q;
    assign bus.out_digits   = out_digits_q;
    assign bus.out_error    = out_error_q;
    assign bus.out_err_code = out_err_code_q;

endmodule

// File: tb/tb_ascii_dec_stream_decoder.sv
// Directed bench for the ASCII decimal stream decoder: decodes a set of fields
// with hand-computed results, exercises backpressure and asynchronous reset.
module tb_ascii_dec_stream_decoder;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;

    ascii_dec_stream_decoder_if #(.WIDTH(20)) bus ();

    ascii_dec_stream_decoder #(
        .WIDTH      (20),
        .MAX_DIGITS (7),
        .TERM_CHAR  (8'h0D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checkOutput("in_ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            sendByte(s[i]);
        end
        sendByte(8'h0D);
    endtask

    task automatic checkResult(input string tag, input logic [31:0] value, input logic [31:0] digits, input logic [31:0] code);
        checkOutput({tag, ".valid"},  {31'd0, bus.out_valid}, 32'd1);
        checkOutput({tag, ".value"},  {12'd0, bus.out_value}, value);
        checkOutput({tag, ".digits"}, {28'd0, bus.out_digits}, digits);
        checkOutput({tag, ".error"},  {31'd0, bus.out_error}, (code != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".code"},   {30'd0, bus.out_err_code}, code);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".in_ready"},  {31'd0, bus.in_ready}, 32'd1);
        checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, ".value"},     {12'd0, bus.out_value}, 32'd0);
        checkOutput({tag, ".digits"},    {28'd0, bus.out_digits}, 32'd0);
        checkOutput({tag, ".error"},     {31'd0, bus.out_error}, 32'd0);
        checkOutput({tag, ".code"},      {30'd0, bus.out_err_code}, 32'd0);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst_n = 1'b1;

        applyStimulus("123456");
        checkResult("dec123456", 32'h1E240, 32'd6, 32'd0);
        applyStimulus("1048575");
        checkResult("max", 32'hFFFFF, 32'd7, 32'd0);
        applyStimulus("1048576");
        checkResult("max_plus1", 32'd0, 32'd6, 32'd2);
        applyStimulus("00000001");
        checkResult("eight_digits", 32'd0, 32'd7, 32'd2);
        applyStimulus("12a4");
        checkResult("bad_char", 32'd0, 32'd2, 32'd1);
        applyStimulus("7");
        checkResult("after_bad", 32'd7, 32'd1, 32'd0);
        applyStimulus("");
        checkResult("empty", 32'd0, 32'd0, 32'd3);
        applyStimulus("5b99999999");
        checkResult("first_err_held", 32'd0, 32'd1, 32'd1);
        applyStimulus("0042");
        checkResult("leading_zeros", 32'd42, 32'd4, 32'd0);
        applyStimulus("0");
        checkResult("zero", 32'd0, 32'd1, 32'd0);

        // Backpressure: the consumer stalls while the next field is already waiting.
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        applyStimulus("99");
        checkResult("bp_first", 32'd99, 32'd2, 32'd0);
        fork
            applyStimulus("5");
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                    checkOutput("bp_hold_value", {12'd0, bus.out_value}, 32'd99);
                    checkOutput("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
                end
                bus.out_ready = 1'b1;
            end
        join
        checkResult("bp_second", 32'd5, 32'd1, 32'd0);

        // Asynchronous reset in the middle of a field, between clock edges.
        sendByte("4");
        sendByte("5");
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("reset_midfield");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("8");
        checkResult("after_reset", 32'd8, 32'd1, 32'd0);

        // Asynchronous reset while a result is being held.
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        applyStimulus("77");
        checkResult("held_before_reset", 32'd77, 32'd2, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("reset_in_done");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus("3");
        checkResult("after_reset2", 32'd3, 32'd1, 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ascii_dec_stream_decoder.md
Name: ascii_dec_stream_decoder

Overview:
Streaming ASCII-decimal-to-binary converter. It generalises the single-digit, fixed-weight combinational decoders to a parametrised, multi-digit accumulator.
- Accepts one ASCII byte per handshake, most-significant digit first. Accumulates value = value*10 + digit and emits one binary result per terminator character.
- Sits between the UART receive byte stream and the command/register-write logic.
- Reports bad characters, empty fields and overflow instead of silently zeroing.

Parameters:
WIDTH, 20, result width in bits; maximum representable value 2^WIDTH-1.
MAX_DIGITS, 7, maximum accepted digit count per number, including leading zeros.
TERM_CHAR, 8'h0D, terminator byte that closes a number.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  8  ASCII byte.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept a byte.
out_value  output  WIDTH  decoded value; 0 when out_error=1.
out_digits  output  4  number of digits accepted in this field (0..MAX_DIGITS).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_error  output  1  field was invalid.
out_err_code  output  2  0=OK, 1=BAD_CHAR, 2=OVERFLOW (value or digit count), 3=EMPTY.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, cnt=0, err_code=0, in_ready=1, out_valid=0, out_value=0, out_digits=0, out_error=0.
- Reset asserted at any time, including mid-field or while out_valid=1, aborts the field and returns to these values. No partial result is ever emitted.
- A byte is accepted when in_valid & in_ready on a rising edge.
- Digit: in_data in 8'h30..8'h39; digit value = in_data - 8'h30.
- State IDLE (in_ready=1):
  - digit -> acc=digit, cnt=1, go to ACCUM.
  - TERM_CHAR -> err_code=EMPTY, go to DONE.
  - any other byte -> err_code=BAD_CHAR, go to FLUSH.
- State ACCUM (in_ready=1):
  - digit with cnt==MAX_DIGITS -> err_code=OVERFLOW, go to FLUSH.
  - digit otherwise -> compute next = acc*10 + digit at WIDTH+4 bits.
    - If next > 2^WIDTH-1 -> err_code=OVERFLOW, go to FLUSH.
    - Else acc=next[WIDTH-1:0], cnt=cnt+1.
  - TERM_CHAR -> go to DONE with err_code=OK.
  - any other byte -> err_code=BAD_CHAR, go to FLUSH.
- State FLUSH (in_ready=1):
  - All bytes are discarded until TERM_CHAR, then go to DONE.
  - err_code holds the first error; later errors do not overwrite it.
  - cnt is frozen at its value when the error occurred.
- State DONE (in_ready=0, out_valid=1):
  - out_value = acc if err_code==OK, else 0.
  - out_digits = cnt; out_error = (err_code!=OK).
  - Outputs are registered and stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready -> acc=0, cnt=0, err_code=0, go to IDLE. in_ready returns to 1 on the following cycle.
- Latency: out_valid rises on the cycle after the edge that accepts the terminator. Minimum field throughput is one byte per cycle plus one DONE cycle per field.
- Backpressure: while in DONE, in_ready=0. The upstream source must hold in_data/in_valid; nothing is dropped.
- Multiplication: acc*10 is formed as (acc<<3)+(acc<<1). It is combinational within a single cycle; no multi-cycle ops.
- Leading zeros are legal and count toward cnt.
- TERM_CHAR has priority over the digit check. If TERM_CHAR is configured as a digit code, it is treated as the terminator.

Test Plan:
- Bytes "123456",0x0D back-to-back, out_ready=1 -> one cycle after 0x0D: out_valid=1, out_value=20'h1E240, out_digits=6, out_err_code=0.
- "1048575",0x0D -> out_value=20'hFFFFF, OK. "1048576",0x0D -> out_value=0, out_error=1, code=2. "00000001",0x0D (8 digits) -> code=2, out_digits=7.
- "12a4",0x0D -> code=1, out_value=0, out_digits=2. Trailing "4" is discarded; a following "7",0x0D decodes to 7 OK.
- Lone 0x0D -> code=3, out_digits=0, out_value=0.
- "99",0x0D then "5",0x0D with out_ready=0 for 10 cycles -> in_ready=0 and out_value=99 held for all 10 cycles; no bytes lost. After out_ready=1, the second result is 5.
- rst_n pulsed low mid-field after "45" (async, between edges) -> all outputs immediately reset. Then "8",0x0D -> out_value=8, not 458.
